// File: rtl/lv1_victim_ctrl.sv
// L1 victim controller: picks a replacement way on a miss, sequences writeback and fill,
// then strobes the LRU block. Also forwards hit-path LRU updates.
module lv1_victim_ctrl #(
  parameter int ASSOC_WID = 2,
  parameter int INDEX_MSB = 11,
  parameter int INDEX_LSB = 6,
  parameter int NUM_WAYS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req,
  input  logic [INDEX_MSB-INDEX_LSB:0] miss_index,
  output logic                         miss_ack,
  input  logic                         hit_update,
  input  logic [INDEX_MSB-INDEX_LSB:0] hit_index,
  input  logic [ASSOC_WID-1:0]         hit_way,
  output logic                         hit_ready,
  input  logic [NUM_WAYS-1:0]          valid_vec,
  input  logic [NUM_WAYS-1:0]          dirty_vec,
  output logic [INDEX_MSB-INDEX_LSB:0] index_proc,
  input  logic [ASSOC_WID-1:0]         lru_replacement_proc,
  output logic                         lru_update,
  output logic [ASSOC_WID-1:0]         blk_accessed_main,
  output logic                         wb_req,
  output logic [ASSOC_WID-1:0]         wb_way,
  input  logic                         wb_ack,
  output logic                         fill_req,
  input  logic                         fill_ack,
  output logic [ASSOC_WID-1:0]         alloc_way,
  output logic                         done
);

  localparam int IW = INDEX_MSB - INDEX_LSB + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HIT_UPD, S_LOOKUP, S_WB, S_FILL, S_UPD
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [ASSOC_WID-1:0] hit_way_q, hit_way_d;
  logic [ASSOC_WID-1:0] alloc_way_q, alloc_way_d;

  logic [ASSOC_WID-1:0] victim;
  logic                 victim_found;
  logic                 victim_dirty;

  // An empty way always beats evicting a live line; LRU only decides for full sets.
  always_comb begin
    victim       = lru_replacement_proc;
    victim_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!victim_found && !valid_vec[w]) begin
        victim       = ASSOC_WID'(w);
        victim_found = 1'b1;
      end
    end
    victim_dirty = valid_vec[victim] && dirty_vec[victim];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      hit_way_q   <= '0;
      alloc_way_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_way_q   <= hit_way_d;
      alloc_way_q <= alloc_way_d;
    end
  end

  // One index register serves both paths: only one of hit/miss is ever in flight.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hit_way_d   = hit_way_q;
    alloc_way_d = alloc_way_q;
    case (state_q)
      S_IDLE: begin
        if (hit_update) begin
          idx_d     = hit_index;
          hit_way_d = hit_way;
          state_d   = S_HIT_UPD;
        end else if (miss_req) begin
          idx_d   = miss_index;
          state_d = S_LOOKUP;
        end
      end
      S_HIT_UPD: state_d = S_IDLE;
      S_LOOKUP: begin
        alloc_way_d = victim;
        state_d     = victim_dirty ? S_WB : S_FILL;
      end
      S_WB:      if (wb_ack)   state_d = S_FILL;
      S_FILL:    if (fill_ack) state_d = S_UPD;
      S_UPD:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_ack          = 1'b0;
    hit_ready         = 1'b0;
    lru_update        = 1'b0;
    blk_accessed_main = '0;
    wb_req            = 1'b0;
    wb_way            = '0;
    fill_req          = 1'b0;
    done              = 1'b0;
    index_proc        = idx_q;
    alloc_way         = alloc_way_q;
    case (state_q)
      S_IDLE: begin
        hit_ready = !rst;
        miss_ack  = !rst && miss_req && !hit_update;
      end
      S_HIT_UPD: begin
        lru_update        = 1'b1;
        blk_accessed_main = hit_way_q;
      end
      S_WB: begin
        wb_req = 1'b1;
        wb_way = alloc_way_q;
      end
      S_FILL: fill_req = 1'b1;
      S_UPD: begin
        lru_update        = 1'b1;
        blk_accessed_main = alloc_way_q;
        done              = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lv1_victim_ctrl.sv
// Bench for lv1_victim_ctrl: directed and random miss flows, hit forwarding, reset abort;
// LRU strobes are checked against a scoreboard filled when stimulus is driven.
module tb_lv1_victim_ctrl;
  localparam int AW = 2;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [IW-1:0] miss_index;
  logic          miss_ack;
  logic          hit_update;
  logic [IW-1:0] hit_index;
  logic [AW-1:0] hit_way;
  logic          hit_ready;
  logic [3:0]    valid_vec;
  logic [3:0]    dirty_vec;
  logic [IW-1:0] index_proc;
  logic [AW-1:0] lru_replacement_proc;
  logic          lru_update;
  logic [AW-1:0] blk_accessed_main;
  logic          wb_req;
  logic [AW-1:0] wb_way;
  logic          wb_ack;
  logic          fill_req;
  logic          fill_ack;
  logic [AW-1:0] alloc_way;
  logic          done;

  always #5 clk = ~clk;

  lv1_victim_ctrl #(.ASSOC_WID(2), .INDEX_MSB(11), .INDEX_LSB(6), .NUM_WAYS(4)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_index(miss_index), .miss_ack(miss_ack),
    .hit_update(hit_update), .hit_index(hit_index), .hit_way(hit_way), .hit_ready(hit_ready),
    .valid_vec(valid_vec), .dirty_vec(dirty_vec), .index_proc(index_proc),
    .lru_replacement_proc(lru_replacement_proc), .lru_update(lru_update),
    .blk_accessed_main(blk_accessed_main), .wb_req(wb_req), .wb_way(wb_way), .wb_ack(wb_ack),
    .fill_req(fill_req), .fill_ack(fill_ack), .alloc_way(alloc_way), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [IW-1:0] idx;
    logic [AW-1:0] way;
    logic          dn;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic prev_lru = 1'b0;

  // Every LRU strobe (or done) must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (lru_update || done) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_idx", 32'(index_proc), 32'(e.idx));
          chk("sb_way", 32'(blk_accessed_main), 32'(e.way));
          chk("sb_done", 32'(done), 32'(e.dn));
          chk("sb_strobe", 32'(lru_update), 32'd1);
        end
        if (lru_update) chk("lru_single", 32'(prev_lru), 32'd0);
      end
      prev_lru = lru_update;
    end else begin
      prev_lru = 1'b0;
    end
  end

  function automatic logic [AW-1:0] model_victim(input logic [3:0] v, input logic [AW-1:0] lru);
    for (int w = 0; w < 4; w++) if (!v[w]) return AW'(w);
    return lru;
  endfunction

  task automatic run_miss(input logic [IW-1:0] idx, input logic [3:0] v, input logic [3:0] d,
                          input logic [AW-1:0] lru, input logic [AW-1:0] exp_way,
                          input bit exp_wb, input int wb_dly, input int fill_dly,
                          input bit early_fill, input bit hit_first, input bit hit_in_fill);
    exp_t x;
    if (hit_first) begin
      x.idx = 7; x.way = 3; x.dn = 1'b0;
      sb.push_back(x);
    end
    x.idx = idx; x.way = exp_way; x.dn = 1'b1;
    sb.push_back(x);

    @(negedge clk);
    miss_req = 1'b1; miss_index = idx;
    valid_vec = v; dirty_vec = d; lru_replacement_proc = lru;
    if (hit_first) begin
      hit_update = 1'b1; hit_index = 7; hit_way = 3;
      #1;
      chk("hit_ready_idle", 32'(hit_ready), 32'd1);
      chk("miss_ack_blocked", 32'(miss_ack), 32'd0);
      @(negedge clk);
      hit_update = 1'b0;
      #1;
      chk("hit_upd_index", 32'(index_proc), 32'd7);
      chk("miss_ack_in_hitupd", 32'(miss_ack), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("miss_ack", 32'(miss_ack), 32'd1);

    @(negedge clk);
    miss_req = 1'b0; fill_ack = early_fill;
    #1;
    chk("lookup_index", 32'(index_proc), 32'(idx));
    chk("lookup_no_req", 32'({wb_req, fill_req, miss_ack}), 32'd0);

    @(negedge clk);
    #1;
    chk("alloc_way", 32'(alloc_way), 32'(exp_way));
    if (exp_wb) begin
      chk("wb_req", 32'(wb_req), 32'd1);
      chk("wb_way", 32'(wb_way), 32'(exp_way));
      for (int i = 0; i < wb_dly; i++) begin
        @(negedge clk); #1;
        chk("wb_hold", 32'(wb_req), 32'd1);
      end
      @(negedge clk);
      wb_ack = 1'b1;
      #1;
      chk("wb_req_at_ack", 32'(wb_req), 32'd1);
      @(negedge clk);
      wb_ack = 1'b0;
      #1;
    end
    chk("no_wb_in_fill", 32'(wb_req), 32'd0);
    chk("fill_req", 32'(fill_req), 32'd1);
    if (hit_in_fill) begin
      hit_update = 1'b1; hit_index = 12; hit_way = 1;
      x.idx = 12; x.way = 1; x.dn = 1'b0;
      sb.push_back(x);
      #1;
      chk("hit_ready_fill", 32'(hit_ready), 32'd0);
    end
    if (!early_fill) begin
      for (int i = 0; i < fill_dly; i++) begin
        @(negedge clk); #1;
        chk("fill_hold", 32'(fill_req), 32'd1);
        if (hit_in_fill) chk("hit_ready_fill", 32'(hit_ready), 32'd0);
      end
      @(negedge clk);
      fill_ack = 1'b1;
      #1;
      chk("fill_req_at_ack", 32'(fill_req), 32'd1);
    end
    @(negedge clk);
    fill_ack = 1'b0;
    #1;
    chk("upd_done", 32'(done), 32'd1);
    chk("upd_alloc_way", 32'(alloc_way), 32'(exp_way));
    chk("upd_no_req", 32'({wb_req, fill_req}), 32'd0);
    if (hit_in_fill) begin
      @(negedge clk); #1;
      chk("hit_ready_after", 32'(hit_ready), 32'd1);
      @(negedge clk);
      hit_update = 1'b0;
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [3:0]    rv, rd;
    logic [AW-1:0] rl, rw;
    logic [IW-1:0] ri;

    rst = 1'b1;
    miss_req = 1'b0; miss_index = '0; hit_update = 1'b0; hit_index = '0; hit_way = '0;
    valid_vec = '0; dirty_vec = '0; lru_replacement_proc = '0; wb_ack = 1'b0; fill_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", 32'({miss_ack, hit_ready, lru_update, wb_req, fill_req, done}), 32'd0);
    chk("rst_index", 32'(index_proc), 32'd0);
    chk("rst_alloc", 32'({alloc_way, blk_accessed_main, wb_way}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_hit_ready", 32'(hit_ready), 32'd1);

    // cold set, full clean set with a hit parked during FILL, dirty victim, partial set
    run_miss(6'd5,  4'b0000, 4'b0000, 2'd3, 2'd0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0);
    run_miss(6'd10, 4'b1111, 4'b0000, 2'd2, 2'd2, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
    run_miss(6'd33, 4'b1111, 4'b0100, 2'd2, 2'd2, 1'b1, 3, 1, 1'b0, 1'b0, 1'b0);
    run_miss(6'd40, 4'b1011, 4'b1111, 2'd0, 2'd2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    // hit beats a simultaneous miss; same-cycle fill ack
    run_miss(6'd9,  4'b1111, 4'b0000, 2'd1, 2'd1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    // one-cycle writeback of way 3
    run_miss(6'd63, 4'b1111, 4'b1000, 2'd3, 2'd3, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      rv = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      rl = AW'($urandom_range(0, 3));
      ri = IW'($urandom_range(0, 63));
      rw = model_victim(rv, rl);
      run_miss(ri, rv, rd, rl, rw, rv[rw] && rd[rw], $urandom_range(0, 2),
               $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
    end

    // reset while a writeback is outstanding must abort cleanly
    @(negedge clk);
    miss_req = 1'b1; miss_index = 6'd21;
    valid_vec = 4'b1111; dirty_vec = 4'b0001; lru_replacement_proc = 2'd0;
    @(negedge clk);
    miss_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_pre_wb", 32'(wb_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({miss_ack, hit_ready, lru_update, wb_req, fill_req, done}), 32'd0);
    chk("rst_mid_index", 32'(index_proc), 32'd0);
    chk("rst_mid_alloc", 32'({alloc_way, wb_way}), 32'd0);
    @(negedge clk);
    rst = 1'b0; wb_ack = 1'b1; fill_ack = 1'b1;
    #1;
    chk("rst_rel_idle", 32'(hit_ready), 32'd1);
    repeat (4) begin
      @(negedge clk); #1;
      chk("rst_rel_quiet", 32'({wb_req, fill_req, lru_update, done}), 32'd0);
    end
    wb_ack = 1'b0; fill_ack = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
